// File: rtl/hex_share_pkg.sv
// Shared types and constants for the hex_share_sched block: FSM state
// encoding, blank/"1" segment patterns and the active-low digit table.
package hex_share_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DECODE  = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ONE   = 7'h79;

    // Active-low patterns, bit0=a ... bit6=g; entry 15 is the leftmost element.
    localparam logic [15:0][6:0] DIGIT_SEG = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Greater-than-9 test on a 4-bit value; only bits [3:1] matter.
    function automatic logic gt9(input logic [2:0] v_hi);
        return v_hi[2] & (v_hi[1] | v_hi[0]);
    endfunction

endpackage

// File: rtl/hex_share_sched_if.sv
// Request handshake and display bus of hex_share_sched.
// The requester side (switch/counter sources) uses the master modport.
interface hex_share_sched_if #(
    parameter int N_CH  = 4,
    parameter int SEG_W = 7
);
    logic [N_CH-1:0]       req_valid;
    logic [4*N_CH-1:0]     req_value;
    logic [N_CH-1:0]       req_ready;
    logic [SEG_W*N_CH-1:0] hex_ones;
    logic [SEG_W*N_CH-1:0] hex_tens;
    logic                  busy;

    modport master (
        output req_valid, req_value,
        input  req_ready, hex_ones, hex_tens, busy
    );

    modport slave (
        input  req_valid, req_value,
        output req_ready, hex_ones, hex_tens, busy
    );
endinterface

// File: rtl/hex_digit_dec.sv
// Combinational 4-bit to active-low seven-segment decoder (0-9, blank above).
module hex_digit_dec
    import hex_share_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);
    assign o_seg = DIGIT_SEG[i_val];
endmodule

// File: rtl/hex_share_sched.sv
// hex_share_sched: arbitrates N_CH requesters onto one shared
// compare/subtract + seven-segment decoder and latches the two digit
// patterns into the granted channel's display registers.
// Service is IDLE -> CAPTURE -> DECODE -> COMMIT, four cycles per request.
// Optional macro HEX_SHARE_SCHED_FIXED_PRIO_EN: fixed priority (channel 0
// highest) instead of round-robin; the round-robin pointer is then absent.
module hex_share_sched
    import hex_share_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEG_W = 7
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    hex_share_sched_if.slave bus
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [IDX_W-1:0]           w_grant_idx;
    logic [N_CH-1:0]            w_grant;
    logic                       w_any_valid;
    logic                       w_xfer;
    logic [3:0]                 w_sel_val;

    logic [IDX_W-1:0]           r_cap_idx;
    logic [3:0]                 r_cap_val;
    logic                       w_gt9;
    logic [3:0]                 w_ones;
    logic                       r_gt9;
    logic [3:0]                 r_ones;
    logic [6:0]                 w_dec_pat;
    logic [6:0]                 r_pat_ones;
    logic [6:0]                 r_pat_tens;

    logic [N_CH-1:0][SEG_W-1:0] r_hex_ones;
    logic [N_CH-1:0][SEG_W-1:0] r_hex_tens;

`ifdef HEX_SHARE_SCHED_FIXED_PRIO_EN
    // Fixed priority: lowest-index valid channel wins.
    always_comb begin
        w_grant_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                w_grant_idx = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] r_ptr;
    logic             w_found;

    // Round-robin: first valid at or above the pointer, else wrap to the lowest valid.
    always_comb begin
        w_grant_idx = '0;
        w_found     = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!w_found && bus.req_valid[i] && (IDX_W'(i) >= r_ptr)) begin
                w_grant_idx = IDX_W'(i);
                w_found     = 1'b1;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!w_found && bus.req_valid[i]) begin
                w_grant_idx = IDX_W'(i);
                w_found     = 1'b1;
            end
        end
    end

    // Pointer moves just past the channel being committed.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ptr <= '0;
        end else if (r_state == COMMIT) begin
            r_ptr <= (r_cap_idx == IDX_W'(N_CH - 1)) ? '0 : r_cap_idx + 1'b1;
        end
    end
`endif

    assign w_any_valid = |bus.req_valid;
    assign w_xfer      = (r_state == IDLE) && w_any_valid;
    assign w_sel_val   = bus.req_value[{w_grant_idx, 2'b00} +: 4];

    // One-hot ready, only offered while idle.
    always_comb begin
        w_grant = '0;
        if (w_xfer) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.busy      = (r_state != IDLE);

    // Next-state logic: fixed walk through the service states once granted.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_xfer) w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = DECODE;
            DECODE:  w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tens/ones split of the captured value: ones is v-10 when v > 9.
    assign w_gt9  = gt9(r_cap_val[3:1]);
    assign w_ones = w_gt9 ? (r_cap_val - 4'd10) : r_cap_val;

    hex_digit_dec u_dec (
        .i_val (r_ones),
        .o_seg (w_dec_pat)
    );

    // Datapath: capture at handshake, split in CAPTURE, decode in DECODE.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cap_idx  <= '0;
            r_cap_val  <= '0;
            r_gt9      <= 1'b0;
            r_ones     <= '0;
            r_pat_ones <= SEG_BLANK;
            r_pat_tens <= SEG_BLANK;
        end else begin
            if (w_xfer) begin
                r_cap_idx <= w_grant_idx;
                r_cap_val <= w_sel_val;
            end
            if (r_state == CAPTURE) begin
                r_gt9  <= w_gt9;
                r_ones <= w_ones;
            end
            if (r_state == DECODE) begin
                r_pat_ones <= w_dec_pat;
                r_pat_tens <= r_gt9 ? SEG_ONE : SEG_BLANK;
            end
        end
    end

    // Display register file: only the captured channel is written in COMMIT.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hex_ones <= {N_CH{SEG_W'(SEG_BLANK)}};
            r_hex_tens <= {N_CH{SEG_W'(SEG_BLANK)}};
        end else if (r_state == COMMIT) begin
            r_hex_ones[r_cap_idx] <= SEG_W'(r_pat_ones);
            r_hex_tens[r_cap_idx] <= SEG_W'(r_pat_tens);
        end
    end

    assign bus.hex_ones = r_hex_ones;
    assign bus.hex_tens = r_hex_tens;

endmodule

// File: tb/tb_hex_share_sched.sv
// Bench for hex_share_sched: reference model of arbitration, busy window
// and display contents; commits are queued and checked when they fall due.
module tb_hex_share_sched;
    localparam int N_CH  = 4;
    localparam int SEG_W = 7;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hex_share_sched_if #(.N_CH(N_CH), .SEG_W(SEG_W)) bus ();

    hex_share_sched #(.N_CH(N_CH), .SEG_W(SEG_W)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic void cmp(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Decimal digit to active-low segments (a=bit0 ... g=bit6).
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Which channel the scheduler should pick given valids and the next-in-line channel.
    function automatic logic [N_CH-1:0] model_grant(input logic [N_CH-1:0] v, input int ptr);
        logic [N_CH-1:0] g = '0;
        for (int k = 0; k < N_CH; k++) begin
`ifdef HEX_SHARE_SCHED_FIXED_PRIO_EN
            if (v[k] && ptr >= 0) begin
                g[k] = 1'b1;
                return g;
            end
`else
            if (v[(ptr + k) % N_CH]) begin
                g[(ptr + k) % N_CH] = 1'b1;
                return g;
            end
`endif
        end
        return g;
    endfunction

    typedef struct {
        int          ch;
        logic [6:0]  tens;
        logic [6:0]  ones;
        int unsigned due;
    } exp_t;

    exp_t        sbq[$];
    logic [6:0]  m_ones [N_CH];
    logic [6:0]  m_tens [N_CH];
    int          m_ptr = 0;
    int unsigned m_free_at = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin : mon
        logic [N_CH-1:0] exp_rdy;
        logic [N_CH-1:0] hs;
        exp_t            e;
        int              v;
        int              gch;
        exp_rdy = '0;
        if (!rst_n) begin
            sbq.delete();
            for (int i = 0; i < N_CH; i++) begin
                m_ones[i] = 7'h7F;
                m_tens[i] = 7'h7F;
            end
            m_ptr     = 0;
            m_free_at = 0;
        end else begin
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                m_ones[e.ch] = e.ones;
                m_tens[e.ch] = e.tens;
                cmp($sformatf("commit_ones_ch%0d", e.ch), bus.hex_ones[SEG_W*e.ch +: SEG_W], e.ones);
                cmp($sformatf("commit_tens_ch%0d", e.ch), bus.hex_tens[SEG_W*e.ch +: SEG_W], e.tens);
            end
            if (cyc >= m_free_at) exp_rdy = model_grant(bus.req_valid, m_ptr);
        end
        cmp("req_ready", bus.req_ready, exp_rdy);
        cmp("busy", bus.busy, (cyc < m_free_at));
        for (int i = 0; i < N_CH; i++) begin
            cmp($sformatf("disp_ones_ch%0d", i), bus.hex_ones[SEG_W*i +: SEG_W], m_ones[i]);
            cmp($sformatf("disp_tens_ch%0d", i), bus.hex_tens[SEG_W*i +: SEG_W], m_tens[i]);
        end
        hs = bus.req_valid & exp_rdy;
        if (rst_n && hs != 0) begin
            gch = 0;
            for (int i = 0; i < N_CH; i++) if (hs[i]) gch = i;
            v = int'(bus.req_value[4*gch +: 4]);
            e.ch   = gch;
            e.ones = seg_of(v % 10);
            e.tens = (v >= 10) ? 7'h79 : 7'h7F;
            e.due  = cyc + 4;
            sbq.push_back(e);
            m_free_at = cyc + 4;
            m_ptr     = (gch + 1) % N_CH;
        end
    end

    logic [N_CH-1:0] hold_mask = '0;
    logic [N_CH-1:0] last_hs   = '0;
    bit              jitter    = 1'b0;

    task automatic post(input int ch, input logic [3:0] v);
        bus.req_valid[ch]      = 1'b1;
        bus.req_value[4*ch +: 4] = v;
    endtask

    // One clock: drop valid of accepted channels, optionally perturb waiting values.
    task automatic step();
        logic [N_CH-1:0] hs;
        @(negedge clk);
        hs = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~(hs & ~hold_mask);
        if (jitter) begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.req_valid[i] && !hs[i] && $urandom_range(0, 1) == 1)
                    bus.req_value[4*i +: 4] = 4'($urandom_range(0, 15));
            end
        end
        last_hs = hs;
    endtask

    task automatic drain();
        int n = 0;
        while ((bus.req_valid != 0 || bus.busy) && n < 400) begin
            step();
            n++;
        end
        cmp("drain_done", {31'd0, (bus.req_valid != 0 || bus.busy)}, 0);
        repeat (2) step();
    endtask

    initial begin : stim
        bit got;
        bus.req_valid = '0;
        bus.req_value = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (20) step();

        post(2, 4'd13);
        drain();

        post(0, 4'd0); post(1, 4'd9); post(2, 4'd10); post(3, 4'd15);
        drain();

        hold_mask = 4'b1010;
        post(1, 4'd7); post(3, 4'd12);
        repeat (24) step();
        hold_mask = '0;
        drain();

        post(0, 4'd11);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            step();
            got = last_hs[0];
        end
        cmp("midrst_handshake", {31'd0, got}, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("midrst_ready", bus.req_ready, 0);
        cmp("midrst_busy", bus.busy, 0);
        cmp("midrst_ones", bus.hex_ones, {N_CH{7'h7F}});
        cmp("midrst_tens", bus.hex_tens, {N_CH{7'h7F}});
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();

        for (int v = 0; v < 16; v++) begin
            post(0, 4'(v));
            drain();
        end

        jitter = 1'b1;
        repeat (300) begin
            for (int i = 0; i < N_CH; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 3) == 0)
                    post(i, 4'($urandom_range(0, 15)));
            step();
        end
        jitter = 1'b0;
        drain();

        cmp("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hex_share_sched.md
Name: hex_share_sched

Overview:
- Shares one binary-to-two-digit decimal decoder datapath among N_CH requesters.
- The datapath is a compare-greater-than-9, subtract 10, then seven-segment decode.
- Each requester submits a 4-bit value (0-15) over a valid/ready handshake.
- The scheduler arbitrates, sequences the shared decoder and latches both digit patterns into that channel's display register. Sits between switch/counter sources and the board HEX outputs.

Parameters:
- N_CH, 4, number of requesting channels / HEX digit pairs (2..8).
- SEG_W, 7, segment pattern width per digit.

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- req_valid  in  N_CH  per-channel request valid.
- req_value  in  4*N_CH  per-channel value; channel i at bits [4i+3:4i].
- req_ready  out  N_CH  per-channel accept; at most one bit high.
- hex_ones  out  SEG_W*N_CH  ones-digit segments per channel, active-low, bit0=a ... bit6=g.
- hex_tens  out  SEG_W*N_CH  tens-digit segments per channel, active-low.
- busy  out  1  high whenever FSM not in IDLE.

Behaviour:
- Reset (async, RESET_N=0): FSM=IDLE, rr pointer=0, all hex_ones and hex_tens = 7'h7F (blank), req_ready=0, busy=0, capture regs=0.
- FSM states: IDLE -> CAPTURE -> DECODE -> COMMIT -> IDLE. Fixed 4-cycle service; no waits.
- IDLE:
  - Round-robin grant starting at rr pointer over req_valid.
  - req_ready = one-hot grant, combinational from IDLE state, pointer and req_valid.
  - Transfer occurs when req_valid[i] & req_ready[i]; next state CAPTURE.
  - No valid: stay IDLE, req_ready=0.
- CAPTURE:
  - Register channel index and value.
  - Compute gt9 = v[3]&(v[2]|v[1]).
  - ones = gt9 ? v-10 : v (4-bit, result 0..5 when gt9).
- DECODE: drive ones into shared decoder; register its 7-bit pattern. Tens pattern = gt9 ? 7'h79 (segments b,c lit) : 7'h7F (blank).
- COMMIT:
  - Write both patterns into the captured channel's slots; other channels unchanged.
  - rr pointer = captured index+1, wrapping N_CH-1 -> 0. Return to IDLE.
- Latency: handshake edge to updated hex outputs visible = 3 clock edges (registered outputs).
- Max throughput: one request per 4 cycles. Channels not granted hold valid; value may change while unaccepted; the value sampled is the one present at the handshake edge.
- Simultaneous valids: strict round-robin; a continuously requesting channel is served at least once every N_CH services.
- Value 9 -> tens blank, ones "9". Value 10 -> "1","0". Value 15 -> "1","5". Value 0 -> tens blank, ones "0".
- Reset mid-operation: in-flight request dropped, all displays blank; the requester must resubmit.
- Displays hold their last committed pattern indefinitely.

Optional Feature:
- Macro: HEX_SHARE_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, channel 0 highest; rr pointer removed; the lowest-index valid channel is always granted.
- Undefined: round-robin as above.

Decomposition:
- Package hex_share_pkg:
  - state enum (IDLE, CAPTURE, DECODE, COMMIT);
  - SEG_BLANK=7'h7F, SEG_ONE=7'h79;
  - 16-entry active-low digit pattern constant for 0-9 (entries 10-15 = SEG_BLANK).
- One sub-module: hex_digit_dec, 4-bit in -> 7-bit active-low pattern, purely combinational, instantiated once and shared.
- Arbiter, compare/subtract and register file stay in the top module.

Test Plan:
- Reset then idle: all hex_ones/hex_tens = 7'h7F, busy=0, req_ready=0 for 20 cycles with no valid.
- Channel 2 valid, value 4'd13: req_ready[2] high in IDLE. 3 edges after the handshake, ch2 tens=7'h79 and ones=pattern "3"; other channels stay 7'h7F; busy high for exactly 3 cycles.
- All four channels valid simultaneously, values 0,9,10,15:
  - Grants in order 0,1,2,3, spaced 4 cycles apart.
  - Final displays: ch0 blank/"0", ch1 blank/"9", ch2 "1"/"0", ch3 "1"/"5".
- Channel 1 held valid continuously with channel 3 also valid: grants alternate 1,3,1,3. With HEX_SHARE_SCHED_FIXED_PRIO_EN defined, channel 1 is granted every time.
- Assert RESET_N=0 during DECODE of a request for value 11 on ch0: all outputs blank immediately (async). After release, FSM is in IDLE and ch0 is not updated until a new handshake.
- Sweep value 0..15 on channel 0: ones/tens patterns match the decimal split for every value; req_ready is never high in non-IDLE states.
